// File: rtl/mem_sync.sv
// Single-port synchronous word memory with byte enables, registered read and out-of-range flag.
// Optional power-on zeroing sequence enabled by MEM_SYNC_CLEAR_ON_RESET_EN.
module mem_sync #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                REQ,
  input  logic                WR,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [DATA_W-1:0]   IN,
  input  logic [DATA_W/8-1:0] BE,
  output logic                READY,
  output logic [DATA_W-1:0]   OUT,
  output logic                VALID,
  output logic                ERR
);
  localparam int NB  = DATA_W / 8;
  localparam int AW1 = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc, in_rng;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [NB-1:0]     wbe;
  logic              clr;
  logic [ADDR_W-1:0] clr_addr;

  logic [DATA_W-1:0] out_q;
  logic              valid_q, err_q;

  // Extra bit keeps the compare correct when DEPTH == 2**ADDR_W.
  assign in_rng = {1'b0, ADDR} < AW1'(DEPTH);
  assign acc    = REQ && READY;

`ifdef MEM_SYNC_CLEAR_ON_RESET_EN
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    READY   = 1'b0;
    clr     = 1'b0;
    case (state_q)
      CLEAR: begin
        clr = 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE:    READY = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  assign clr_addr = cnt_q;
`else
  assign READY    = 1'b1;
  assign clr      = 1'b0;
  assign clr_addr = '0;
`endif

  // The clear sequence owns the single write port while it runs.
  always_comb begin
    we    = 1'b0;
    waddr = ADDR;
    wdata = IN;
    wbe   = BE;
    if (clr) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = '0;
      wbe   = '1;
    end else if (acc && WR && in_rng) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= acc && !WR;
      err_q   <= acc && !in_rng;
      if (acc && !WR) out_q <= in_rng ? mem[ADDR] : '0;
    end
  end

  assign OUT   = out_q;
  assign VALID = valid_q;
  assign ERR   = err_q;
endmodule

// File: tb/tb_mem_sync.sv
// Scoreboard bench for mem_sync: two instances (DEPTH 256 and 200) share one stimulus stream.
module tb_mem_sync;
  logic        CLK = 1'b0, RST_N = 1'b0, REQ = 1'b0, WR = 1'b0;
  logic [7:0]  ADDR = '0;
  logic [31:0] IN = '0;
  logic [3:0]  BE = '0;
  logic        r [2];
  logic        v [2];
  logic        e [2];
  logic [31:0] o [2];

  always #5 CLK = ~CLK;

  mem_sync #(.DATA_W(32), .ADDR_W(8), .DEPTH(256)) u256 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WR(WR), .ADDR(ADDR), .IN(IN), .BE(BE),
    .READY(r[0]), .OUT(o[0]), .VALID(v[0]), .ERR(e[0]));
  mem_sync #(.DATA_W(32), .ADDR_W(8), .DEPTH(200)) u200 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .WR(WR), .ADDR(ADDR), .IN(IN), .BE(BE),
    .READY(r[1]), .OUT(o[1]), .VALID(v[1]), .ERR(e[1]));

`ifdef MEM_SYNC_CLEAR_ON_RESET_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [31:0] out;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t        q [2][$];
  int          depth [2] = '{256, 200};
  bit   [31:0] mm [2][256];
  bit          known [256];
  logic [31:0] cur [2] = '{32'h0, 32'h0};
  int          cyc = 0;
  int          rel = 0;
  int          n_err = 0, n_chk = 0;
  exp_t        mx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Response monitor: pops the entry due this cycle; otherwise no pulse allowed.
  always @(negedge CLK) begin
    if (RST_N) begin
      for (int i = 0; i < 2; i++) begin
        if (q[i].size() > 0 && q[i][0].due == cyc) begin
          mx = q[i].pop_front();
          chk($sformatf("valid%0d", i), 32'(v[i]), 32'(mx.valid));
          chk($sformatf("err%0d", i), 32'(e[i]), 32'(mx.err));
          if (mx.valid) cur[i] = mx.out;
        end else begin
          chk($sformatf("nopulse%0d", i), {30'h0, v[i], e[i]}, 32'h0);
        end
        chk($sformatf("out%0d", i), o[i], cur[i]);
      end
    end
  end

  task automatic acc(input bit wr, input bit [7:0] a, input bit [31:0] d, input bit [3:0] be);
    exp_t x;
    bit   inr;
    @(negedge CLK);
    REQ = 1'b1; WR = wr; ADDR = a; IN = d; BE = be;
    for (int i = 0; i < 2; i++) begin
      if (r[i]) begin
        inr     = int'(a) < depth[i];
        x.due   = cyc + 1;
        x.valid = !wr;
        x.err   = !inr;
        x.out   = (!wr && inr) ? mm[i][a] : 32'h0;
        if (wr && inr)
          for (int b = 0; b < 4; b++) if (be[b]) mm[i][a][8*b +: 8] = d[8*b +: 8];
        if (!wr || !inr) q[i].push_back(x);
      end
    end
    if (wr && be == 4'hF && r[0]) known[a] = 1'b1;
  endtask

  task automatic idle();
    @(negedge CLK);
    REQ = 1'b0; WR = 1'b0;
  endtask

  task automatic do_rst(input int hold);
    @(negedge CLK);
    #2;
    RST_N = 1'b0; REQ = 1'b0; WR = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(v[i]), 32'h0);
      chk($sformatf("rst_err%0d", i), 32'(e[i]), 32'h0);
      chk($sformatf("rst_out%0d", i), o[i], 32'h0);
      chk($sformatf("rst_ready%0d", i), 32'(r[i]), CLR_EN ? 32'h0 : 32'h1);
      q[i].delete();
      cur[i] = 32'h0;
    end
`ifdef MEM_SYNC_CLEAR_ON_RESET_EN
    for (int a = 0; a < 256; a++) begin
      mm[0][a] = 32'h0; mm[1][a] = 32'h0; known[a] = 1'b1;
    end
`endif
    repeat (hold) @(negedge CLK);
    RST_N = 1'b1;
    rel   = cyc;
  endtask

  task automatic wait_clear();
    int at [2];
    at = '{-1, -1};
    for (int n = 0; n < 400 && (at[0] < 0 || at[1] < 0); n++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) if (at[i] < 0 && r[i]) at[i] = cyc - rel;
    end
    for (int i = 0; i < 2; i++)
      chk($sformatf("ready_after%0d", i), 32'(at[i]), CLR_EN ? 32'(depth[i]) : 32'h1);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit [7:0]  a;
    bit [31:0] d;
    bit [3:0]  be;
    int        op;

    repeat (2) @(negedge CLK);
    do_rst(2);
    wait_clear();
`ifdef MEM_SYNC_CLEAR_ON_RESET_EN
    acc(1'b0, 8'h7F, 32'h0, 4'h0);
`endif
    // Byte merge, BE=0 write, read right after write.
    acc(1'b1, 8'd5, 32'hDEADBEEF, 4'b1111);
    acc(1'b1, 8'd5, 32'h11223344, 4'b0101);
    acc(1'b0, 8'd5, 32'h0, 4'h0);
    acc(1'b1, 8'd5, 32'h00000000, 4'b0000);
    acc(1'b0, 8'd5, 32'h0, 4'h0);
    idle();
    // Out-of-range on the 200-word instance; word 10 guards against aliasing.
    acc(1'b1, 8'd10, 32'hCAFEF00D, 4'hF);
    acc(1'b1, 8'd210, 32'hFFFFFFFF, 4'hF);
    acc(1'b0, 8'd210, 32'h0, 4'h0);
    acc(1'b1, 8'd199, 32'h12345678, 4'hF);
    acc(1'b0, 8'd199, 32'h0, 4'h0);
    acc(1'b0, 8'd10, 32'h0, 4'h0);
    acc(1'b1, 8'd255, 32'h0BADF00D, 4'hF);
    acc(1'b0, 8'd255, 32'h0, 4'h0);
    idle();
    // Back-to-back reads.
    acc(1'b1, 8'd1, 32'hA1A1A1A1, 4'hF);
    acc(1'b1, 8'd2, 32'hB2B2B2B2, 4'hF);
    acc(1'b1, 8'd3, 32'hC3C3C3C3, 4'hF);
    acc(1'b0, 8'd1, 32'h0, 4'h0);
    acc(1'b0, 8'd2, 32'h0, 4'h0);
    acc(1'b0, 8'd3, 32'h0, 4'h0);
    idle();

    for (int k = 0; k < 200; k++) begin
      a  = 8'($urandom_range(0, 255));
      d  = $urandom;
      be = 4'($urandom);
      op = $urandom_range(0, 3);
      if (op == 0) idle();
      else if (op == 1 || !known[a]) acc(1'b1, a, d, known[a] ? be : 4'hF);
      else acc(1'b0, a, 32'h0, 4'h0);
    end

    // Reset while a read response is on the outputs.
    acc(1'b0, 8'd5, 32'h0, 4'h0);
    do_rst(1);
`ifdef MEM_SYNC_CLEAR_ON_RESET_EN
    repeat (50) @(negedge CLK);
    acc(1'b1, 8'd7, 32'hA5A5A5A5, 4'hF);
    idle();
    repeat (47) @(negedge CLK);
    do_rst(1);
`endif
    wait_clear();
    acc(1'b0, 8'd5, 32'h0, 4'h0);
    acc(1'b0, 8'd7, 32'h0, 4'h0);
    acc(1'b0, 8'd210, 32'h0, 4'h0);
    idle();
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 2; i++) chk($sformatf("drain%0d", i), 32'(q[i].size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_sync.md
MEM_SYNC -- requirements
Module: mem_sync

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W, 32, data word width in bits; multiple of 8
  ADDR_W, 8, address width in bits
  DEPTH, 256, implemented words; 1 <= DEPTH <= 2**ADDR_W
REQ-002 Ports SHALL be, one per line:
  CLK    input   1         single clock; all state on rising edge
  RST_N  input   1         asynchronous, active-low reset
  REQ    input   1         access request
  WR     input   1         1 = write, 0 = read; sampled with REQ
  ADDR   input   ADDR_W    word address
  IN     input   DATA_W    write data
  BE     input   DATA_W/8  byte enables; bit i selects IN[8i+7:8i]
  READY  output  1         block can accept a request this cycle
  OUT    output  DATA_W    registered read data
  VALID  output  1         OUT holds fresh read data this cycle
  ERR    output  1         previous accepted access was out of range
REQ-003 The block SHALL use one clock, CLK, and an asynchronous, active-low reset, RST_N.

Function
REQ-004 Storage SHALL be DEPTH words of DATA_W bits, single port, one access per cycle.
REQ-005 A request SHALL be accepted on a rising CLK edge where REQ=1 and READY=1; with READY=0, REQ SHALL be ignored, with no state change.
REQ-006 For an accepted write with ADDR<DEPTH, only bytes with BE[i]=1 SHALL be updated; BE=0 SHALL leave memory unchanged and still count as accepted.
REQ-007 An accepted read SHALL have latency 1: OUT=mem[ADDR] and VALID=1 for exactly the cycle after the accepting edge.
REQ-008 A write SHALL NOT change OUT; OUT SHALL hold its last read value until the next accepted read.
REQ-009 A read accepted on the edge directly after a write to the same address SHALL return the newly written bytes.
REQ-010 For an accepted access with ADDR>=DEPTH: writes SHALL be discarded, reads SHALL return OUT=0 with VALID=1, and ERR=1 SHALL be asserted for one cycle, aligned with the VALID slot.
REQ-011 VALID and ERR SHALL be single-cycle pulses; back-to-back reads SHALL give VALID=1 on consecutive cycles.
REQ-012 The state machine SHALL have the states CLEAR and IDLE: READY=0 in CLEAR and READY=1 in IDLE; IDLE SHALL have no exits other than reset.
REQ-013 In CLEAR, a counter SHALL write 0 to word k on cycle k (k=0..DEPTH-1); after the edge that writes word DEPTH-1, the state SHALL be IDLE.

Reset
REQ-014 While RST_N=0: OUT=0, VALID=0, ERR=0, the clear counter=0, and the state SHALL be CLEAR (macro defined) or IDLE (macro undefined).
REQ-015 Reset asserted during CLEAR SHALL abort the clear; on release, the clear SHALL restart from word 0.
REQ-016 Reset SHALL NOT alter memory contents directly; only the CLEAR sequence zeroes memory.

Configuration
REQ-017 Macro MEM_SYNC_CLEAR_ON_RESET_EN SHALL control the CLEAR state.
  Defined: after reset, the block SHALL spend DEPTH cycles in CLEAR with READY=0, then hold all words at 0.
  Undefined: the CLEAR state and counter SHALL be omitted; READY=1 from the first edge after RST_N rises; memory content is undefined until written.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
  a) Macro defined, DEPTH=256, reset released -> READY=0 for 256 cycles, then 1; a read of addr 0x7F -> OUT=0, VALID=1 one cycle later.
  b) Write 0xDEADBEEF to addr 5 with BE=4'b1111, then write 0x11223344 with BE=4'b0101, then read addr 5 on the next edge -> OUT=0xDE22BE44, VALID=1 one cycle after the read.
  c) DEPTH=200: write 0xFFFFFFFF to addr 210 -> ERR pulse, memory unchanged; read addr 210 -> OUT=0, VALID=1, ERR=1; read addr 199 -> ERR=0.
  d) REQ=1 write during CLEAR (READY=0) -> ignored; after IDLE, a read of the same address returns 0.
  e) RST_N pulsed low at clear cycle 100 -> OUT/VALID/ERR=0 immediately; READY returns 1 only 256 cycles after release.
  f) Reads of addrs 1,2,3 on consecutive edges -> VALID high for 3 consecutive cycles, with OUT=mem[1], mem[2], mem[3] in order.
